moesi_bus_arbiter: RTL and testbench
====================================

MOESI_BUS_ARBITER -- requirements
Module: moesi_bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4, number of caches on the snoop bus; legal range 2..8.
REQ-002 SHALL have parameter SRC_WID, default 2, width of core index; equals ceil(log2(NUM_CORES)).
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  NUM_CORES  per-core bus request.
REQ-006 SHALL have port req_type  input  2*NUM_CORES  per-core type, core k at bits [2k+1:2k]: 00 read_miss, 01 write_miss, 10 write_hit (upgrade), 11 reserved.
REQ-007 SHALL have port req_ready  output  NUM_CORES  one-hot grant pulse; request accepted.
REQ-008 SHALL have port snoop_valid  output  1  probe broadcast active.
REQ-009 SHALL have port snoop_write  output  1  0 = probe_read_hit class, 1 = probe_write_hit class.
REQ-010 SHALL have port snoop_src  output  SRC_WID  index of requesting core.
REQ-011 SHALL have port snoop_ack  input  NUM_CORES  per-core probe acknowledge.
REQ-012 SHALL have port snoop_hit  input  NUM_CORES  line held non-INVALID; valid with snoop_ack.
REQ-013 SHALL have port snoop_dirty  input  NUM_CORES  line held MODIFIED or OWNED; valid with snoop_ack.
REQ-014 SHALL have port resp_valid  output  NUM_CORES  one-hot completion pulse to requester.
REQ-015 SHALL have port resp_shared  output  1  read_miss only: some other cache hit.
REQ-016 SHALL have port resp_exclusive  output  1  read_miss only: no other cache hit.
REQ-017 SHALL have port resp_supplier_valid  output  1  some other cache dirty; that cache supplies data.
REQ-018 SHALL have port resp_supplier  output  SRC_WID  lowest-index dirty core.
REQ-019 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-020 SHALL implement FSM states IDLE, SNOOP, RESP.
REQ-021 Eligible request: req_valid[k]=1 and req_type k != 11. Reserved type is never granted.
REQ-022 IDLE: if any request is eligible, grant one by round-robin in the same cycle. Grant means req_ready[k]=1 for that cycle, latch k and type, clear ack/hit/dirty accumulators, then go to SNOOP.
REQ-023 Round-robin: search starts at pointer p, ascending and wrapping mod NUM_CORES; after granting k, p becomes (k+1) mod NUM_CORES; p = 0 after reset.
REQ-024 SNOOP: snoop_valid=1; snoop_src=k; snoop_write=0 for read_miss, 1 for write_miss/write_hit.
REQ-025 SNOOP: each cycle, OR snoop_ack of cores other than k into ack_mask. On the same acking cycle, OR that core's snoop_hit/snoop_dirty into the accumulators. snoop_ack[k] and hit/dirty without ack are ignored.
REQ-026 SNOOP exits to RESP on the cycle when ack_mask, including acks that cycle, covers every core except k. Acks may arrive in any cycle, order, or all at once. Repeated acks are harmless.
REQ-027 RESP lasts one cycle.
- resp_valid[k]=1.
- Read_miss: resp_shared = any hit; resp_exclusive = no hit.
- Writes: both 0.
- resp_supplier_valid = any dirty; resp_supplier = lowest dirty index, else 0.
- Next state IDLE.
REQ-028 Minimum latency: grant at cycle T, snoop_valid at T+1, resp_valid at T+2. Back-to-back grant no earlier than T+3.
REQ-029 snoop_ack outside SNOOP is ignored. req_valid during SNOOP/RESP is not granted. A requester holds req_valid until req_ready.
REQ-030 All outputs not defined as active in the current state SHALL be 0.

Reset
REQ-031 With reset=1 at a posedge, the FSM SHALL enter IDLE and p SHALL become 0. Accumulators, latched k and type SHALL clear. All outputs SHALL be 0 from the next cycle, including when reset is asserted mid-SNOOP or RESP.
REQ-032 reset SHALL dominate any simultaneous request or ack.

Verification
REQ-033 NUM_CORES=4, core 1 read_miss, cores 0/2/3 ack with no hit the cycle after grant -> req_ready=0010 at T, snoop_write=0 and snoop_src=1 at T+1, resp_valid=0010 with resp_exclusive=1 at T+2.
REQ-034 Core 0 read_miss, core 3 ack with hit=1 and dirty=1, cores 1/2 ack two cycles later -> resp_shared=1, resp_supplier_valid=1, resp_supplier=3.
REQ-035 Cores 0..3 all request continuously after reset -> grant order 0,1,2,3,0; each grant is followed by its resp before the next grant.
REQ-036 Core 2 write_hit, others ack with hit=1 -> snoop_write=1, resp_shared=0, resp_exclusive=0; core 2 requesting with type 11 -> never granted, busy stays 0.
REQ-037 reset asserted in SNOOP with acks pending -> resp_valid never pulses, all outputs 0 next cycle; first subsequent grant goes to the lowest requesting core from p=0.

Source files
------------

// File: rtl/moesi_bus_arbiter.sv
// Snoop-bus arbiter for a MOESI cache cluster: round-robin grant, probe broadcast,
// ack/hit/dirty collection and a one-cycle response to the requester.
module moesi_bus_arbiter #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned SRC_WID   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_CORES-1:0]   req_valid,
  input  logic [2*NUM_CORES-1:0] req_type,
  output logic [NUM_CORES-1:0]   req_ready,
  output logic                   snoop_valid,
  output logic                   snoop_write,
  output logic [SRC_WID-1:0]     snoop_src,
  input  logic [NUM_CORES-1:0]   snoop_ack,
  input  logic [NUM_CORES-1:0]   snoop_hit,
  input  logic [NUM_CORES-1:0]   snoop_dirty,
  output logic [NUM_CORES-1:0]   resp_valid,
  output logic                   resp_shared,
  output logic                   resp_exclusive,
  output logic                   resp_supplier_valid,
  output logic [SRC_WID-1:0]     resp_supplier,
  output logic                   busy
);

  typedef enum logic [1:0] {StIdle, StSnoop, StResp} state_e;

  state_e               state_q, state_d;
  logic [SRC_WID-1:0]   ptr_q, ptr_d;
  logic [SRC_WID-1:0]   src_q, src_d;
  logic [1:0]           type_q, type_d;
  logic [NUM_CORES-1:0] ack_q, ack_d;
  logic [NUM_CORES-1:0] hit_q, hit_d;
  logic [NUM_CORES-1:0] dirty_q, dirty_d;

  logic [NUM_CORES-1:0] eligible;
  logic                 grant_found;
  logic [SRC_WID-1:0]   grant_idx;
  logic [NUM_CORES-1:0] others;
  logic [NUM_CORES-1:0] new_ack;

  // Reserved type 11 is never eligible; search wraps from the round-robin pointer.
  always_comb begin
    int unsigned cand;
    cand        = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      eligible[k] = req_valid[k] && (req_type[2*k +: 2] != 2'b11);
    end
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      cand = (32'(ptr_q) + i) % NUM_CORES;
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_idx   = SRC_WID'(cand);
      end
    end
  end

  assign others  = ~(NUM_CORES'(1) << src_q);
  assign new_ack = snoop_ack & others;

  always_comb begin
    state_d             = state_q;
    ptr_d               = ptr_q;
    src_d               = src_q;
    type_d              = type_q;
    ack_d               = ack_q;
    hit_d               = hit_q;
    dirty_d             = dirty_q;
    req_ready           = '0;
    snoop_valid         = 1'b0;
    snoop_write         = 1'b0;
    snoop_src           = '0;
    resp_valid          = '0;
    resp_shared         = 1'b0;
    resp_exclusive      = 1'b0;
    resp_supplier_valid = 1'b0;
    resp_supplier       = '0;
    case (state_q)
      StIdle: begin
        // Gating with reset keeps the grant pulse from escaping while held in reset.
        if (grant_found && !reset) begin
          req_ready[grant_idx] = 1'b1;
          src_d                = grant_idx;
          type_d               = req_type[2*32'(grant_idx) +: 2];
          ack_d                = '0;
          hit_d                = '0;
          dirty_d              = '0;
          ptr_d                = SRC_WID'((32'(grant_idx) + 1) % NUM_CORES);
          state_d              = StSnoop;
        end
      end
      StSnoop: begin
        snoop_valid = 1'b1;
        snoop_src   = src_q;
        snoop_write = (type_q != 2'b00);
        ack_d       = ack_q | new_ack;
        hit_d       = hit_q | (snoop_hit & new_ack);
        dirty_d     = dirty_q | (snoop_dirty & new_ack);
        if ((ack_d & others) == others) state_d = StResp;
      end
      StResp: begin
        resp_valid[src_q] = 1'b1;
        if (type_q == 2'b00) begin
          resp_shared    = |hit_q;
          resp_exclusive = ~|hit_q;
        end
        resp_supplier_valid = |dirty_q;
        for (int k = int'(NUM_CORES) - 1; k >= 0; k--) begin
          if (dirty_q[k]) resp_supplier = SRC_WID'(k);
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      src_q   <= '0;
      type_q  <= '0;
      ack_q   <= '0;
      hit_q   <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      src_q   <= src_d;
      type_q  <= type_d;
      ack_q   <= ack_d;
      hit_q   <= hit_d;
      dirty_q <= dirty_d;
    end
  end

endmodule

// File: tb/tb_moesi_bus_arbiter.sv
// Directed bench for moesi_bus_arbiter: inputs driven and outputs sampled on the falling edge.
module tb_moesi_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_valid;
  logic [7:0] req_type;
  logic [3:0] req_ready;
  logic       snoop_valid;
  logic       snoop_write;
  logic [1:0] snoop_src;
  logic [3:0] snoop_ack;
  logic [3:0] snoop_hit;
  logic [3:0] snoop_dirty;
  logic [3:0] resp_valid;
  logic       resp_shared;
  logic       resp_exclusive;
  logic       resp_supplier_valid;
  logic [1:0] resp_supplier;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  moesi_bus_arbiter #(
    .NUM_CORES(4),
    .SRC_WID  (2)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .req_valid          (req_valid),
    .req_type           (req_type),
    .req_ready          (req_ready),
    .snoop_valid        (snoop_valid),
    .snoop_write        (snoop_write),
    .snoop_src          (snoop_src),
    .snoop_ack          (snoop_ack),
    .snoop_hit          (snoop_hit),
    .snoop_dirty        (snoop_dirty),
    .resp_valid         (resp_valid),
    .resp_shared        (resp_shared),
    .resp_exclusive     (resp_exclusive),
    .resp_supplier_valid(resp_supplier_valid),
    .resp_supplier      (resp_supplier),
    .busy               (busy)
  );

  // Advance to the next falling edge; callers then set inputs and check after #1.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 4'b1111; req_type = 8'h00;
    snoop_ack = 4'hf; snoop_hit = 4'hf; snoop_dirty = 4'hf;
    step(); step(); #1;
    n_vec++;
    if (req_ready !== 4'b0000) begin
      n_err++; $display("FAIL reset_ready: got %b want 0000", req_ready);
    end
    n_vec++;
    if ({snoop_valid, busy, resp_valid} !== 6'b0) begin
      n_err++; $display("FAIL reset_outs: snoop_valid/busy/resp_valid got %b want 000000",
                        {snoop_valid, busy, resp_valid});
    end
    req_valid = 4'b0; snoop_ack = 4'b0; snoop_hit = 4'b0; snoop_dirty = 4'b0;
    step(); reset = 1'b0;
  endtask

  task automatic test_read_exclusive();
    step(); req_valid = 4'b0010; req_type = 8'h00; #1;
    n_vec++;
    if (req_ready !== 4'b0010) begin
      n_err++; $display("FAIL rdx_grant: got %b want 0010", req_ready);
    end
    step(); req_valid = 4'b0;
    snoop_ack = 4'b1101; snoop_hit = 4'b0010; #1;  // own-core hit without ack is ignored
    n_vec++;
    if ({snoop_valid, snoop_write, snoop_src, busy} !== 5'b1_0_01_1) begin
      n_err++; $display("FAIL rdx_snoop: valid/write/src/busy got %b want 10011",
                        {snoop_valid, snoop_write, snoop_src, busy});
    end
    step(); snoop_ack = 4'b0; snoop_hit = 4'b0; #1;
    n_vec++;
    if ({resp_valid, resp_shared, resp_exclusive, resp_supplier_valid} !== 7'b0010_0_1_0) begin
      n_err++; $display("FAIL rdx_resp: valid/sh/ex/supv got %b want 0010010",
                        {resp_valid, resp_shared, resp_exclusive, resp_supplier_valid});
    end
    step(); #1;
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL rdx_idle: busy got %b want 0", busy);
    end
  endtask

  task automatic test_dirty_supplier();
    req_valid = 4'b0001; req_type = 8'h00; #1;
    n_vec++;
    if (req_ready !== 4'b0001) begin
      n_err++; $display("FAIL dirty_grant: got %b want 0001", req_ready);
    end
    step(); req_valid = 4'b0;
    snoop_ack = 4'b1000; snoop_hit = 4'b1000; snoop_dirty = 4'b1000; #1;
    n_vec++;
    if (snoop_src !== 2'd0) begin
      n_err++; $display("FAIL dirty_src: got %0d want 0", snoop_src);
    end
    step(); snoop_ack = 4'b0001; snoop_hit = 4'b0; snoop_dirty = 4'b0; #1;  // own ack only
    step(); snoop_ack = 4'b0110; #1;
    n_vec++;
    if ({snoop_valid, resp_valid} !== 5'b1_0000) begin
      n_err++; $display("FAIL dirty_wait: snoop_valid/resp_valid got %b want 10000",
                        {snoop_valid, resp_valid});
    end
    step(); snoop_ack = 4'b0; #1;
    n_vec++;
    if ({resp_valid, resp_shared, resp_exclusive, resp_supplier_valid, resp_supplier}
        !== 9'b0001_1_0_1_11) begin
      n_err++; $display("FAIL dirty_resp: valid/sh/ex/supv/sup got %b want 000110111",
                        {resp_valid, resp_shared, resp_exclusive, resp_supplier_valid,
                         resp_supplier});
    end
    step();
  endtask

  task automatic test_round_robin();
    int unsigned order [5] = '{0, 1, 2, 3, 0};
    logic [3:0]  onehot;
    reset = 1'b1; step(); reset = 1'b0;
    req_valid = 4'b1111; req_type = 8'b01_00_00_00;  // core 3 write_miss, others read_miss
    for (int i = 0; i < 5; i++) begin
      onehot = 4'b0001 << order[i];
      #1;
      n_vec++;
      if (req_ready !== onehot) begin
        n_err++; $display("FAIL rr_grant%0d: got %b want %b", i, req_ready, onehot);
      end
      step(); snoop_ack = ~onehot; #1;
      n_vec++;
      if ({snoop_src, snoop_write, req_ready} !== {2'(order[i]), order[i] == 3, 4'b0}) begin
        n_err++; $display("FAIL rr_snoop%0d: src/write/ready got %b want %b", i,
                          {snoop_src, snoop_write, req_ready},
                          {2'(order[i]), order[i] == 3, 4'b0});
      end
      step(); snoop_ack = 4'b0; #1;
      n_vec++;
      if ({resp_valid, resp_exclusive, req_ready} !== {onehot, order[i] != 3, 4'b0}) begin
        n_err++; $display("FAIL rr_resp%0d: valid/ex/ready got %b want %b", i,
                          {resp_valid, resp_exclusive, req_ready},
                          {onehot, order[i] != 3, 4'b0});
      end
      step();
    end
    req_valid = 4'b0;
  endtask

  task automatic test_write_hit_reserved();
    req_valid = 4'b0100; req_type = 8'h20; #1;
    n_vec++;
    if (req_ready !== 4'b0100) begin
      n_err++; $display("FAIL wh_grant: got %b want 0100", req_ready);
    end
    step(); req_valid = 4'b0; snoop_ack = 4'b1011; snoop_hit = 4'b1011; #1;
    n_vec++;
    if ({snoop_write, snoop_src} !== 3'b1_10) begin
      n_err++; $display("FAIL wh_snoop: write/src got %b want 110", {snoop_write, snoop_src});
    end
    step(); snoop_ack = 4'b0; snoop_hit = 4'b0; #1;
    n_vec++;
    if ({resp_valid, resp_shared, resp_exclusive, resp_supplier_valid} !== 7'b0100_0_0_0) begin
      n_err++; $display("FAIL wh_resp: valid/sh/ex/supv got %b want 0100000",
                        {resp_valid, resp_shared, resp_exclusive, resp_supplier_valid});
    end
    step(); req_valid = 4'b0100; req_type = 8'h30;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_vec++;
      if ({req_ready, busy} !== 5'b0) begin
        n_err++; $display("FAIL reserved%0d: ready/busy got %b want 00000", i,
                          {req_ready, busy});
      end
      step();
    end
    req_valid = 4'b0; req_type = 8'h00;
  endtask

  task automatic test_reset_mid_snoop();
    req_valid = 4'b0100; #1;  // pointer sits at 3 after the previous grant of core 2
    n_vec++;
    if (req_ready !== 4'b0100) begin
      n_err++; $display("FAIL mid_grant: got %b want 0100", req_ready);
    end
    step(); req_valid = 4'b0; snoop_ack = 4'b0001; reset = 1'b1;
    step(); reset = 1'b0; snoop_ack = 4'b1010; #1;
    n_vec++;
    if ({req_ready, snoop_valid, snoop_write, snoop_src, resp_valid, resp_shared,
         resp_exclusive, resp_supplier_valid, resp_supplier, busy} !== 19'b0) begin
      n_err++; $display("FAIL mid_outs: packed outputs got %b want all 0",
                        {req_ready, snoop_valid, snoop_write, snoop_src, resp_valid,
                         resp_shared, resp_exclusive, resp_supplier_valid, resp_supplier,
                         busy});
    end
    step(); snoop_ack = 4'b0; req_valid = 4'b1010; #1;
    n_vec++;
    if ({req_ready, resp_valid} !== 8'b0010_0000) begin
      n_err++; $display("FAIL mid_regrant: ready/resp got %b want 00100000",
                        {req_ready, resp_valid});
    end
    step(); req_valid = 4'b1000; snoop_ack = 4'b1101; #1;
    step(); snoop_ack = 4'b0; #1;
    n_vec++;
    if (resp_valid !== 4'b0010) begin
      n_err++; $display("FAIL mid_resp: got %b want 0010", resp_valid);
    end
    step(); req_valid = 4'b0;
  endtask

  initial begin
    test_reset();
    test_read_exclusive();
    test_dirty_supplier();
    test_round_robin();
    test_write_hit_reserved();
    test_reset_mid_snoop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
